// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter: shares one memory bus between instruction fetch (I) and data access (D).
// Latency: m_valid one cycle after a request is seen in IDLE; addr_ok/data_ok are combinational pass-through.
// Backpressure: one transaction outstanding; requesters hold valid until their addr_ok arrives.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_valid/i_addr              I request; i_addr_ok, i_data_ok, i_rdata back to I
//   d_valid/d_addr/d_write/
//   d_size/d_strobe/d_wdata     D request; d_addr_ok, d_data_ok, d_rdata back to D
//   m_valid/m_addr/m_write/
//   m_size/m_strobe/m_wdata     downstream request; m_addr_ok, m_data_ok, m_rdata from memory
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  owner_t     r_owner;
  owner_t     w_owner_nxt;
  req_t       r_req;
  req_t       w_req_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;

  logic       w_grant_i;
  logic       w_m_valid;
  logic       w_addr_ok;
  logic       w_data_ok;
  logic       w_run;

  // D wins ties unless I has already lost LIMIT grants in a row.
  assign w_grant_i = i_valid & (~d_valid | (r_starve_cnt == LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_req        <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_req        <= w_req_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_req_nxt    = r_req;
    w_starve_nxt = r_starve_cnt;
    w_m_valid    = 1'b0;
    w_addr_ok    = 1'b0;
    w_data_ok    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_owner_nxt = OWN_NONE;
        if (w_grant_i) begin
          w_owner_nxt      = OWN_I;
          w_req_nxt.addr   = i_addr;
          w_req_nxt.write  = 1'b0;
          w_req_nxt.size   = 2'd2;
          w_req_nxt.strobe = 4'h0;
          w_req_nxt.wdata  = 32'h0;
          w_starve_nxt     = '0;
          w_state_nxt      = S_REQ;
        end else if (d_valid) begin
          w_owner_nxt      = OWN_D;
          w_req_nxt.addr   = d_addr;
          w_req_nxt.write  = d_write;
          w_req_nxt.size   = d_size;
          w_req_nxt.strobe = d_strobe;
          w_req_nxt.wdata  = d_wdata;
          // Only a grant that I actually lost counts toward starvation.
          if (!i_valid) begin
            w_starve_nxt = '0;
          end else if (r_starve_cnt != LIMIT) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
          end
          w_state_nxt      = S_REQ;
        end
      end

      S_REQ: begin
        w_m_valid = 1'b1;
        // m_data_ok without m_addr_ok is meaningless here and is dropped.
        if (m_addr_ok) begin
          w_addr_ok = 1'b1;
          if (m_data_ok) begin
            w_data_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (m_data_ok) begin
          w_data_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is high, even in the cycle before
  // the reset edge has cleared the state registers.
  assign w_run = ~reset;

  assign m_valid  = w_run & w_m_valid;
  assign m_addr   = w_run ? r_req.addr   : 32'h0;
  assign m_write  = w_run & r_req.write;
  assign m_size   = w_run ? r_req.size   : 2'd0;
  assign m_strobe = w_run ? r_req.strobe : 4'h0;
  assign m_wdata  = w_run ? r_req.wdata  : 32'h0;

  assign i_addr_ok = w_run & w_addr_ok & (r_owner == OWN_I);
  assign i_data_ok = w_run & w_data_ok & (r_owner == OWN_I);
  assign i_rdata   = i_data_ok ? m_rdata : 32'h0;

  assign d_addr_ok = w_run & w_addr_ok & (r_owner == OWN_D);
  assign d_data_ok = w_run & w_data_ok & (r_owner == OWN_D);
  assign d_rdata   = d_data_ok ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
// Downstream memory responses are driven directly by each step.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic [31:0] d_addr;
  logic        d_write;
  logic [1:0]  d_size;
  logic [3:0]  d_strobe;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_write;
  logic [1:0]  m_size;
  logic [3:0]  m_strobe;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_size(m_size),
    .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_write = 1'b0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;

    // ---- reset: outputs quiet even with a request pending ----
    cyc();
    i_valid = 1'b1; i_addr = 32'hBFC0_0000;
    cyc();
    #1;
    chk("rst_m_valid",  {31'b0, m_valid},   32'd0);
    chk("rst_i_addrok", {31'b0, i_addr_ok}, 32'd0);
    chk("rst_d_dataok", {31'b0, d_data_ok}, 32'd0);
    chk("rst_m_addr",   m_addr,             32'h0);
    i_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // ---- single I read ----
    i_valid = 1'b1; i_addr = 32'hBFC0_0000;
    #1;
    chk("i1_idle_mvalid", {31'b0, m_valid}, 32'd0);
    cyc();
    m_addr_ok = 1'b1;
    #1;
    chk("i1_req_mvalid",  {31'b0, m_valid},   32'd1);
    chk("i1_req_maddr",   m_addr,             32'hBFC0_0000);
    chk("i1_req_mwrite",  {31'b0, m_write},   32'd0);
    chk("i1_req_msize",   {30'b0, m_size},    32'd2);
    chk("i1_i_addrok",    {31'b0, i_addr_ok}, 32'd1);
    chk("i1_d_addrok",    {31'b0, d_addr_ok}, 32'd0);
    cyc();
    i_valid = 1'b0; m_addr_ok = 1'b0;
    #1;
    chk("i1_wait_mvalid", {31'b0, m_valid},   32'd0);
    chk("i1_wait_dataok", {31'b0, i_data_ok}, 32'd0);
    cyc();
    m_data_ok = 1'b1; m_rdata = 32'h3C08_BFC0;
    #1;
    chk("i1_i_dataok", {31'b0, i_data_ok}, 32'd1);
    chk("i1_i_rdata",  i_rdata,            32'h3C08_BFC0);
    chk("i1_d_dataok", {31'b0, d_data_ok}, 32'd0);
    chk("i1_d_rdata",  d_rdata,            32'h0);
    cyc();
    m_data_ok = 1'b0; m_rdata = '0;
    #1;
    chk("i1_idle2_mvalid", {31'b0, m_valid},   32'd0);
    chk("i1_idle2_dataok", {31'b0, i_data_ok}, 32'd0);

    // ---- simultaneous requests: D first, then I ----
    i_valid = 1'b1; i_addr = 32'hBFC0_0004;
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h8000_0010; d_size = 2'd2;
    d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
    cyc();
    m_addr_ok = 1'b1;
    #1;
    chk("sim_d_maddr",   m_addr,              32'h8000_0010);
    chk("sim_d_mwrite",  {31'b0, m_write},    32'd1);
    chk("sim_d_mwdata",  m_wdata,             32'hDEAD_BEEF);
    chk("sim_d_mstrobe", {28'b0, m_strobe},   32'hF);
    chk("sim_d_addrok",  {31'b0, d_addr_ok},  32'd1);
    chk("sim_i_addrok",  {31'b0, i_addr_ok},  32'd0);
    cyc();
    d_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    #1;
    chk("sim_d_dataok", {31'b0, d_data_ok}, 32'd1);
    chk("sim_i_dataok", {31'b0, i_data_ok}, 32'd0);
    cyc();
    m_data_ok = 1'b0;
    #1;
    chk("sim_idle_mvalid", {31'b0, m_valid}, 32'd0);
    cyc();
    // I granted; also same-cycle addr_ok + data_ok
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    chk("sim_i_maddr",   m_addr,             32'hBFC0_0004);
    chk("sim_i_mwrite",  {31'b0, m_write},   32'd0);
    chk("sim_i_mwdata",  m_wdata,            32'h0);
    chk("sim_i_mstrobe", {28'b0, m_strobe},  32'h0);
    chk("same_i_addrok", {31'b0, i_addr_ok}, 32'd1);
    chk("same_i_dataok", {31'b0, i_data_ok}, 32'd1);
    chk("same_i_rdata",  i_rdata,            32'h1234_5678);
    chk("same_d_dataok", {31'b0, d_data_ok}, 32'd0);
    cyc();
    i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    #1;
    chk("same_idle_mvalid", {31'b0, m_valid}, 32'd0);

    // ---- starvation guard: 4 D grants, then I ----
    i_addr = 32'hBFC0_0100; d_addr = 32'h8000_0200; d_write = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; d_valid = 1'b1; m_addr_ok = 1'b0; m_data_ok = 1'b0;
      #1;
      chk($sformatf("stv%0d_idle_mvalid", k), {31'b0, m_valid}, 32'd0);
      cyc();
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'(k);
      #1;
      chk($sformatf("stv%0d_maddr", k), m_addr, (k == 4) ? 32'hBFC0_0100 : 32'h8000_0200);
      chk($sformatf("stv%0d_d_addrok", k), {31'b0, d_addr_ok}, (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("stv%0d_i_addrok", k), {31'b0, i_addr_ok}, (k == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    i_valid = 1'b0; d_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    cyc();

    // ---- reset in D's WAIT ----
    d_valid = 1'b1; d_addr = 32'h8000_0020; d_size = 2'd1; d_strobe = 4'h3; d_wdata = 32'h0000_AAAA;
    cyc();
    m_addr_ok = 1'b1;
    #1;
    chk("rw_d_addrok", {31'b0, d_addr_ok}, 32'd1);
    chk("rw_msize",    {30'b0, m_size},    32'd1);
    cyc();
    d_valid = 1'b0; m_addr_ok = 1'b0; reset = 1'b1;
    #1;
    chk("rw_inrst_maddr",  m_addr,              32'h0);
    chk("rw_inrst_mvalid", {31'b0, m_valid},    32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rw_post_maddr",   m_addr,              32'h0);
    chk("rw_post_mwdata",  m_wdata,             32'h0);
    chk("rw_post_mvalid",  {31'b0, m_valid},    32'd0);
    m_data_ok = 1'b1; m_rdata = 32'h0000_0055;
    #1;
    chk("rw_late_dataok", {31'b0, d_data_ok}, 32'd0);
    chk("rw_late_rdata",  d_rdata,            32'h0);
    cyc();
    m_data_ok = 1'b0; m_rdata = '0;

    // ---- idle with spurious m_data_ok ----
    for (int k = 0; k < 3; k++) begin
      m_data_ok = 1'b1;
      #1;
      chk($sformatf("sp%0d_mvalid", k),   {31'b0, m_valid},   32'd0);
      chk($sformatf("sp%0d_i_dataok", k), {31'b0, i_data_ok}, 32'd0);
      chk($sformatf("sp%0d_d_dataok", k), {31'b0, d_data_ok}, 32'd0);
      cyc();
    end
    m_data_ok = 1'b0;

    // ---- m_data_ok in REQ without addr_ok is dropped; addr_ok in WAIT ignored ----
    d_valid = 1'b1; d_addr = 32'h8000_0040; d_size = 2'd0; d_strobe = 4'h1;
    cyc();
    m_data_ok = 1'b1;
    #1;
    chk("rq_spur_dataok", {31'b0, d_data_ok}, 32'd0);
    chk("rq_spur_addrok", {31'b0, d_addr_ok}, 32'd0);
    chk("rq_spur_mvalid", {31'b0, m_valid},   32'd1);
    cyc();
    m_data_ok = 1'b0; m_addr_ok = 1'b1;
    #1;
    chk("rq_hold_maddr", m_addr,             32'h8000_0040);
    chk("rq_addrok",     {31'b0, d_addr_ok}, 32'd1);
    cyc();
    d_valid = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    chk("wt_addrok_ign", {31'b0, d_addr_ok}, 32'd0);
    chk("wt_dataok",     {31'b0, d_data_ok}, 32'd1);
    chk("wt_rdata",      d_rdata,            32'hCAFE_F00D);
    cyc();
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    #1;
    chk("end_mvalid", {31'b0, m_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
